// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores push bytes into a TX FIFO and a
// baud-divided shifter serialises them onto tx; loads return status/config combinationally.
module mmio_uart_tx #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    input  logic [1:0]  RWE,
    output logic [31:0] RD,
    output logic        tx,
    output logic        irq
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [15:0]        baud_cnt_q, baud_cnt_d;
    logic [15:0]        div_lat_q, div_lat_d;
    logic [15:0]        baud_div_q, baud_div_d;
    logic               ie_q, ie_d;
    logic               ovf_q, ovf_d;
    logic               tx_q, tx_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [7:0]         mem_d [FIFO_DEPTH];

    logic               wr_s;
    logic [1:0]         reg_sel_s;
    logic               push_req_s;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               empty_s;
    logic               bit_done_s;
    logic [31:0]        status_s;
    logic               unused_bits_s;

    function automatic logic [3:0] sat_count(input logic [CNT_W-1:0] c);
        logic [31:0] w;
        w = 32'(c);
        if (w > 32'd15) begin
            return 4'hF;
        end else begin
            return w[3:0];
        end
    endfunction

    assign unused_bits_s = ^{A[31:4], A[1:0], WD[31:16]};

    // Bus decode and FIFO handshake; push is judged on the pre-edge fill level only
    always_comb begin
        wr_s       = sel && (RWE != 2'b00);
        reg_sel_s  = A[3:2];
        push_req_s = wr_s && (reg_sel_s == 2'd0);
        full_s     = (count_q == CNT_W'(FIFO_DEPTH));
        empty_s    = (count_q == {CNT_W{1'b0}});
        push_s     = push_req_s && !full_s;
        pop_s      = (state_q == IDLE) && !empty_s;
        bit_done_s = (baud_cnt_q == div_lat_q);
    end

    // FIFO storage, pointers and fill count
    always_comb begin
        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = WD[7:0];
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Software-visible configuration and sticky overflow
    always_comb begin
        if (wr_s && (reg_sel_s == 2'd2)) begin
            baud_div_d = WD[15:0];
        end else begin
            baud_div_d = baud_div_q;
        end
        if (wr_s && (reg_sel_s == 2'd3)) begin
            ie_d = WD[0];
        end else begin
            ie_d = ie_q;
        end
        if (push_req_s && full_s) begin
            ovf_d = 1'b1;
        end else if (wr_s && (reg_sel_s == 2'd1) && WD[3]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // State register and all other flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            baud_cnt_q <= 16'd0;
            div_lat_q  <= 16'd0;
            baud_div_q <= DEFAULT_DIV;
            ie_q       <= 1'b0;
            ovf_q      <= 1'b0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            baud_cnt_q <= baud_cnt_d;
            div_lat_q  <= div_lat_d;
            baud_div_q <= baud_div_d;
            ie_q       <= ie_d;
            ovf_q      <= ovf_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    // Next-state logic; the divider is latched at frame start so mid-frame writes wait a frame
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        baud_cnt_d = baud_cnt_q;
        div_lat_d  = div_lat_q;
        case (state_q)
            IDLE: begin
                if (!empty_s) begin
                    state_d    = START;
                    shift_d    = mem_q[rd_ptr_q];
                    div_lat_d  = baud_div_q;
                    baud_cnt_d = 16'd0;
                end else begin
                    state_d    = IDLE;
                end
            end
            START: begin
                if (bit_done_s) begin
                    baud_cnt_d = 16'd0;
                    bit_idx_d  = 3'd0;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_done_s) begin
                    baud_cnt_d = 16'd0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_done_s) begin
                    baud_cnt_d = 16'd0;
                    state_d    = IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: tx is registered from the next state so it changes on the same edge as the FSM
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        irq = (state_q == IDLE) && empty_s && ie_q;
    end

    assign tx = tx_q;

    // Zero-latency read mux
    always_comb begin
        status_s = {24'd0, sat_count(count_q), ovf_q, empty_s, full_s, (state_q != IDLE)};
        if (sel) begin
            case (reg_sel_s)
                2'd1:    RD = status_s;
                2'd2:    RD = {16'd0, baud_div_q};
                2'd3:    RD = {31'd0, ie_q};
                default: RD = 32'd0;
            endcase
        end else begin
            RD = 32'd0;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, frame timing, FIFO overflow,
// divider latching, interrupt and asynchronous reset mid-frame.
module tb_mmio_uart_tx;

    logic        clk;
    logic        rst;
    logic        sel;
    logic [31:0] A;
    logic [31:0] WD;
    logic [1:0]  RWE;
    logic [31:0] RD;
    logic        tx;
    logic        irq;

    int checks = 0;
    int errors = 0;

    mmio_uart_tx #(
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sel (sel),
        .A   (A),
        .WD  (WD),
        .RWE (RWE),
        .RD  (RD),
        .tx  (tx),
        .irq (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        sel = 1'b1;
        A   = addr;
        WD  = data;
        RWE = 2'b11;
        cyc();
        sel = 1'b0;
        RWE = 2'b00;
        A   = 32'd0;
        WD  = 32'd0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        sel = 1'b1;
        A   = addr;
        RWE = 2'b00;
        #1;
        chk(tag, RD, exp);
        sel = 1'b0;
        A   = 32'd0;
    endtask

    task automatic rx_byte(input int period, output logic [7:0] b);
        int n = 0;
        while (tx !== 1'b0 && n < 5000) begin
            cyc();
            n++;
        end
        chk("rx_start", {31'd0, tx}, 32'd0);
        repeat (period / 2) cyc();
        chk("rx_start_mid", {31'd0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (period) cyc();
            b[i] = tx;
        end
        repeat (period) cyc();
        chk("rx_stop", {31'd0, tx}, 32'd1);
    endtask

    initial begin
        logic [9:0]  frame;
        logic [9:0]  frame2;
        logic [7:0]  b;
        int          lows;

        rst = 1'b0;
        sel = 1'b0;
        A   = 32'd0;
        WD  = 32'd0;
        RWE = 2'b00;

        // Reset defaults
        repeat (3) cyc();
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        A = 32'h4;
        #1;
        chk("rd_unselected", RD, 32'd0);
        rst = 1'b1;
        cyc();
        chk_rd("reset_status", 32'h4, 32'h0000_0004);
        chk_rd("reset_bauddiv", 32'h8, 32'h0000_000F);
        chk_rd("reset_ctrl", 32'hC, 32'h0000_0000);
        chk_rd("txdata_reads_zero", 32'h0, 32'h0000_0000);
        chk("reset_irq_after", {31'd0, irq}, 32'd0);

        // Single frame 0xA5, 4 clocks per bit
        wr(32'h8, 32'd3);
        chk_rd("bauddiv_3", 32'h8, 32'd3);
        wr(32'h0, 32'h0000_00A5);
        chk("frame1_tx_before_start", {31'd0, tx}, 32'd1);
        chk_rd("status_after_push", 32'h4, 32'h0000_0010);
        frame = {1'b1, 8'hA5, 1'b0};
        for (int k = 0; k < 40; k++) begin
            cyc();
            chk("frame1_tx", {31'd0, tx}, {31'd0, frame[k / 4]});
            if (k == 0) chk_rd("status_busy", 32'h4, 32'h0000_0005);
        end
        cyc();
        chk("frame1_idle_tx", {31'd0, tx}, 32'd1);
        chk_rd("frame1_idle_status", 32'h4, 32'h0000_0004);

        // FIFO fill and overflow
        wr(32'h8, 32'd100);
        for (int i = 0; i < 10; i++) wr(32'h0, i);
        chk_rd("fifo_full_ovf_status", 32'h4, 32'h0000_008B);
        wr(32'h4, 32'h0000_0008);
        chk_rd("ovf_cleared_status", 32'h4, 32'h0000_0083);
        for (int i = 0; i < 9; i++) begin
            rx_byte(101, b);
            chk("fifo_frame_data", {24'd0, b}, i);
        end
        repeat (60) cyc();
        chk_rd("fifo_drained_status", 32'h4, 32'h0000_0004);
        lows = 0;
        for (int i = 0; i < 150; i++) begin
            cyc();
            if (tx !== 1'b1) lows++;
        end
        chk("no_tenth_frame", lows, 32'd0);

        // Divider change mid-frame takes effect on the following frame
        wr(32'h8, 32'd1);
        wr(32'h0, 32'h0000_0055);
        wr(32'h0, 32'h0000_0081);
        frame  = {1'b1, 8'h55, 1'b0};
        frame2 = {1'b1, 8'h81, 1'b0};
        for (int k = 0; k < 20; k++) begin
            chk("div_old_tx", {31'd0, tx}, {31'd0, frame[k / 2]});
            if (k == 4) begin
                sel = 1'b1;
                A   = 32'h8;
                WD  = 32'd7;
                RWE = 2'b11;
            end
            cyc();
            if (k == 4) begin
                sel = 1'b0;
                RWE = 2'b00;
                A   = 32'd0;
                WD  = 32'd0;
            end
        end
        chk("div_gap_idle", {31'd0, tx}, 32'd1);
        chk_rd("bauddiv_7", 32'h8, 32'd7);
        cyc();
        for (int j = 0; j < 80; j++) begin
            chk("div_new_tx", {31'd0, tx}, {31'd0, frame2[j / 8]});
            cyc();
        end
        chk("div_new_end_tx", {31'd0, tx}, 32'd1);
        chk_rd("div_end_status", 32'h4, 32'h0000_0004);

        // Interrupt
        wr(32'hC, 32'h0000_0001);
        chk_rd("ctrl_ie", 32'hC, 32'h0000_0001);
        chk("irq_idle_empty", {31'd0, irq}, 32'd1);
        wr(32'h8, 32'd0);
        wr(32'h0, 32'h0000_003C);
        chk("irq_low_after_push", {31'd0, irq}, 32'd0);
        frame = {1'b1, 8'h3C, 1'b0};
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("irq_frame_tx", {31'd0, tx}, {31'd0, frame[k]});
            chk("irq_busy_low", {31'd0, irq}, 32'd0);
        end
        cyc();
        chk("irq_after_stop", {31'd0, irq}, 32'd1);
        wr(32'h0, 32'h0000_0011);
        chk("irq_after_store", {31'd0, irq}, 32'd0);
        repeat (15) cyc();
        chk("irq_second_idle", {31'd0, irq}, 32'd1);
        wr(32'hC, 32'h0000_0000);
        chk("irq_ie_off", {31'd0, irq}, 32'd0);

        // Asynchronous reset during DATA bit 3 with three bytes queued
        wr(32'h8, 32'd3);
        for (int i = 0; i < 4; i++) wr(32'h0, 32'h0000_0000);
        repeat (15) cyc();
        chk("pre_reset_tx_low", {31'd0, tx}, 32'd0);
        chk_rd("pre_reset_status", 32'h4, 32'h0000_0031);
        rst = 1'b0;
        #1;
        chk("reset_mid_tx", {31'd0, tx}, 32'd1);
        chk("reset_mid_irq", {31'd0, irq}, 32'd0);
        repeat (2) cyc();
        #2;
        rst = 1'b1;
        cyc();
        chk_rd("post_reset_status", 32'h4, 32'h0000_0004);
        chk_rd("post_reset_bauddiv", 32'h8, 32'h0000_000F);
        chk_rd("post_reset_ctrl", 32'hC, 32'h0000_0000);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (tx !== 1'b1) lows++;
        end
        chk("post_reset_no_frames", lows, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
